// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter among NUM_REQ requesters
//
// Ports:
//   clk1         system clock (transmitter system clock, not the baud tick)
//   rst          asynchronous, active-high reset
//   req          per-requester request level
//   req_data     requester i byte at [i*Data_length +: Data_length]
//   grant        one-hot, one-cycle pulse: requester's byte accepted
//   tx_data      byte to transmitter datain, held from launch until the next grant
//   tx_send      send strobe to the transmitter, held until tx_done is seen low
//   tx_done      from transmitter, high = idle or frame finished (asynchronous)
//   busy         high from launch until the frame completes or times out
//   active_id    index of the requester currently owning the transmitter
//   frame_done   one-cycle pulse when the owned frame completes
//   err_timeout  one-cycle pulse when tx_done fails to fall within START_TIMEOUT
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int Data_length   = 8,
  parameter int START_TIMEOUT = 1024,
  parameter int GAP_CYCLES    = 4,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk1,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*Data_length-1:0]   req_data,
  output logic [NUM_REQ-1:0]               grant,
  output logic [Data_length-1:0]           tx_data,
  output logic                             tx_send,
  input  logic                             tx_done,
  output logic                             busy,
  output logic [ID_W-1:0]                  active_id,
  output logic                             frame_done,
  output logic                             err_timeout
);

  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t                   state_q, state_d;
  logic                     done_meta, done_sync;
  logic [ID_W-1:0]          rr_q, rr_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic [GW-1:0]            gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]       grant_d;
  logic [Data_length-1:0]   tx_data_d;
  logic                     tx_send_d, busy_d, frame_done_d, err_timeout_d;
  logic [ID_W-1:0]          active_id_d;

  logic                     win_found;
  logic [ID_W-1:0]          win_idx, cand;
  logic [Data_length-1:0]   slot [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*Data_length +: Data_length];
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    grant_d       = '0;
    tx_data_d     = tx_data;
    tx_send_d     = tx_send;
    busy_d        = busy;
    active_id_d   = active_id;
    frame_done_d  = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && done_sync) begin
          grant_d     = NUM_REQ'(1) << win_idx;
          tx_data_d   = slot[win_idx];
          active_id_d = win_idx;
          rr_d        = win_idx;
          busy_d      = 1'b1;
          tx_send_d   = 1'b1;
          to_cnt_d    = '0;
          state_d     = START;
        end
      end
      START: begin
        if (!done_sync) begin
          tx_send_d = 1'b0;
          state_d   = BUSY;
        end else if (to_cnt_q == TO_LAST) begin
          // Transmitter never acknowledged: drop the byte, keep rr advanced.
          tx_send_d     = 1'b0;
          busy_d        = 1'b0;
          err_timeout_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      BUSY: begin
        // Only entered after tx_done was seen low, so high here is the rising edge.
        if (done_sync) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_done comes from the baud domain; reset to 0 so nothing launches until
  // the transmitter has been seen idle through the synchroniser.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= tx_done;
      done_sync <= done_meta;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= ID_W'(NUM_REQ - 1);
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      grant       <= '0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      busy        <= 1'b0;
      active_id   <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      grant       <= grant_d;
      tx_data     <= tx_data_d;
      tx_send     <= tx_send_d;
      busy        <= busy_d;
      active_id   <= active_id_d;
      frame_done  <= frame_done_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int DL  = 8;
  localparam int TO  = 16;
  localparam int GAP = 4;

  logic              clk1 = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DL-1:0]  req_data = '0;
  logic              tx_done = 1'b1;
  logic [NR-1:0]     grant;
  logic [DL-1:0]     tx_data;
  logic              tx_send, busy, frame_done, err_timeout;
  logic [1:0]        active_id;

  always #5 clk1 = ~clk1;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .Data_length(DL), .START_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk1(clk1), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done), .busy(busy),
    .active_id(active_id), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: timestamps of launch and frame end, plus the byte owner.
  int          rr, idle_from, launch;
  bit          m_busy, m_send, s1, s2;
  logic [NR-1:0] e_grant;
  logic [DL-1:0] e_data;
  int          e_id;
  bit          e_fd, e_to;

  // Stimulus controls and observation counters.
  bit hold_req, rnd_req, rnd_to, tx_never, tx_force_low;
  bit tx_act, tx_ign;
  int tx_t, tx_dly, tx_len, fixed_dly;
  int n_grant, n_g2, n_fd, n_to;
  int order[$];

  task automatic model_edge();
    bit sync;
    int w;
    sync = s2; s2 = s1; s1 = tx_done;
    e_grant = '0; e_fd = 1'b0; e_to = 1'b0;
    if (!m_busy) begin
      if (cyc >= idle_from && req != '0 && sync) begin
        w = -1;
        for (int k = 1; k <= NR; k++)
          if (w < 0 && req[(rr + k) % NR]) w = (rr + k) % NR;
        e_grant = NR'(1) << w;
        e_data  = req_data[w*DL +: DL];
        e_id    = w;
        rr      = w;
        m_busy  = 1'b1;
        m_send  = 1'b1;
        launch  = cyc;
      end
    end else if (m_send) begin
      if (!sync) m_send = 1'b0;
      else if (cyc - launch == TO) begin
        m_send = 1'b0; m_busy = 1'b0; e_to = 1'b1; idle_from = cyc + GAP + 1;
      end
    end else if (sync) begin
      e_fd = 1'b1; m_busy = 1'b0; idle_from = cyc + GAP + 1;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check("grant", grant, e_grant);
    check("tx_send", tx_send, m_send);
    check("busy", busy, m_busy);
    check("frame_done", frame_done, e_fd);
    check("err_timeout", err_timeout, e_to);
    check("tx_data", tx_data, e_data);
    check("active_id", active_id, e_id);
  endtask

  task automatic observe();
    for (int i = 0; i < NR; i++)
      if (grant[i]) begin
        n_grant++;
        order.push_back(i);
        if (i == 2) n_g2++;
      end
    if (frame_done) n_fd++;
    if (err_timeout) n_to++;
  endtask

  task automatic drive_req();
    if (!hold_req)
      for (int i = 0; i < NR; i++) begin
        if (grant[i]) req[i] = 1'b0;
        else if (rnd_req) begin
          if (!req[i] && $urandom_range(0, 5) == 0) begin
            req[i] = 1'b1;
            req_data[i*DL +: DL] = 8'($urandom);
          end else if (req[i] && $urandom_range(0, 40) == 0) req[i] = 1'b0;
        end
      end
  endtask

  // Transmitter stand-in: after send, holds tx_done high tx_dly cycles, low tx_len cycles.
  task automatic drive_tx();
    if (tx_force_low) tx_done = 1'b0;
    else if (tx_act) begin
      tx_t++;
      tx_done = !(tx_t >= tx_dly && tx_t < tx_dly + tx_len);
      if (tx_t >= tx_dly + tx_len) tx_act = 1'b0;
    end else begin
      tx_done = 1'b1;
      if (!tx_send) tx_ign = 1'b0;
      else if (!tx_ign && !tx_never) begin
        if (rnd_to && $urandom_range(0, 7) == 0) tx_ign = 1'b1;
        else begin
          tx_act = 1'b1;
          tx_t   = 0;
          tx_dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
          tx_len = $urandom_range(4, 10);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk1);
    model_edge();
    @(negedge clk1);
    check_outputs();
    observe();
    drive_req();
    drive_tx();
  endtask

  task automatic clear_counts();
    n_grant = 0; n_g2 = 0; n_fd = 0; n_to = 0;
    order.delete();
  endtask

  // Called between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_active_id", active_id, 0);
    rr = NR - 1; idle_from = 0; launch = 0; cyc = 0;
    m_busy = 1'b0; m_send = 1'b0; s1 = 1'b0; s2 = 1'b0;
    e_grant = '0; e_data = '0; e_id = 0; e_fd = 1'b0; e_to = 1'b0;
    tx_act = 1'b0; tx_ign = 1'b0;
    tx_done = !tx_force_low;
    clear_counts();
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic wait_busy_phase(input string tag);
    int n;
    n = 0;
    while (!(m_busy && !m_send) && n < 40) begin
      step();
      n++;
    end
    check(tag, (m_busy && !m_send), 1);
  endtask

  initial begin
    int n;
    int exp_order[6];
    exp_order = '{0, 1, 3, 0, 1, 3};
    #2;
    do_reset();

    // Single request from requester 1, transmitter answers 3 cycles after send.
    fixed_dly = 3;
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    repeat (40) step();
    check("single_grants", n_grant, 1);
    check("single_frame_done", n_fd, 1);
    check("single_busy_after", busy, 0);
    fixed_dly = 0;

    // Contention: 1011 held continuously.
    do_reset();
    for (int i = 0; i < NR; i++) req_data[i*DL +: DL] = 8'(8'h10 + i);
    hold_req = 1'b1;
    req = 4'b1011;
    n = 0;
    while (order.size() < 6 && n < 400) begin
      step();
      n++;
    end
    check("contend_count", order.size() >= 6, 1);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("contend_order%0d", i), order[i], exp_order[i]);
    hold_req = 1'b0;
    req = '0;
    repeat (40) step();

    // Timeout: transmitter never drops tx_done.
    do_reset();
    tx_never = 1'b1;
    req = 4'b0101;
    repeat (60) step();
    check("timeout_count", n_to, 2);
    check("timeout_no_fd", n_fd, 0);
    check("timeout_grants", n_grant, 2);
    tx_never = 1'b0;

    // Withdraw: req[2] pulsed for one cycle while serving requester 0.
    do_reset();
    req = 4'b0001;
    wait_busy_phase("withdraw_reach_busy");
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    repeat (40) step();
    check("withdraw_no_grant2", n_g2, 0);
    check("withdraw_idle_busy", busy, 0);
    check("withdraw_idle_grant", grant, 0);

    // Reset while a frame is in flight.
    do_reset();
    req = 4'b0001;
    wait_busy_phase("midrst_reach_busy");
    req = 4'b0001;
    do_reset();
    repeat (20) step();
    check("midrst_first_grant", (order.size() > 0) ? order[0] : -1, 0);

    // tx_done low while idle blocks arbitration.
    tx_force_low = 1'b1;
    do_reset();
    req = 4'b0001;
    repeat (20) step();
    check("txlow_no_grant", n_grant, 0);
    tx_force_low = 1'b0;
    repeat (20) step();
    check("txlow_then_grant", n_grant, 1);

    // Randomized traffic, including dropped sends and withdrawn requests.
    do_reset();
    rnd_req = 1'b1;
    rnd_to = 1'b1;
    repeat (3000) step();
    rnd_req = 1'b0;
    req = '0;
    repeat (60) step();
    rnd_to = 1'b0;
    repeat (30) step();
    check("random_all_frames_closed", n_fd + n_to, n_grant);
    check("random_some_grants", n_grant > 20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
